// File: rtl/risc16_mem_pkg.sv
// Shared types and constants for the RISC16 memory responder.
//   state_t      : responder FSM state (IDLE, LOAD, RUN)
//   MMIO_*       : byte offsets of the four MMIO registers within the window
//   NOP          : instruction word returned when no fetch is served
package risc16_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned DATA_W = 16;

    localparam logic [2:0] MMIO_GPIO_OUT = 3'd0;
    localparam logic [2:0] MMIO_GPIO_IN  = 3'd2;
    localparam logic [2:0] MMIO_CYCLE    = 3'd4;
    localparam logic [2:0] MMIO_STATUS   = 3'd6;

    localparam logic [DATA_W-1:0] NOP = 16'h0000;

endpackage

// File: rtl/risc16_ram.sv
// Word RAM with two asynchronous read ports and one synchronous write port.
// Contents are not reset.
//   clk            : write clock
//   iaddr / irdata : instruction read port (word index / data)
//   daddr / drdata : data read port (word index / data)
//   we / waddr / wdata : write port, already muxed by the caller
module risc16_ram
    import risc16_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] irdata,
    input  logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] drdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous reads: the core samples them at its next edge.
    assign irdata = mem[iaddr];
    assign drdata = mem[daddr];

endmodule

// File: rtl/risc16_mem_resp.sv
// Memory-side responder for the RISC16 core: zero-wait instruction/data RAM,
// a small MMIO window (GPIO, cycle counter, status) and a boot loader that
// fills RAM from a streaming port while holding the core in reset.
// Optional: define RISC16_MEM_RESP_CYCLE_CNT_EN to build the CYCLE counter;
// without it CYCLE reads 0 and writes to it are ignored.
//   clk, rst           : clock, asynchronous active-high reset
//   iaddr, ioe, irdata : instruction fetch port (combinational read)
//   daddr, dwdata, doe, dwe, drdata : data load/store port
//   ld_start, ld_valid, ld_last, ld_data, ld_ready : image load stream
//   cpu_rst            : core reset, high whenever not in RUN
//   gpio_in, gpio_out  : MMIO general-purpose pins
module risc16_mem_resp
    import risc16_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       iaddr,
    input  logic              ioe,
    output logic [DATA_W-1:0] irdata,
    input  logic [15:0]       daddr,
    input  logic [DATA_W-1:0] dwdata,
    input  logic              doe,
    input  logic              dwe,
    output logic [DATA_W-1:0] drdata,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_last,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_rst,
    input  logic [DATA_W-1:0] gpio_in,
    output logic [DATA_W-1:0] gpio_out
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] ptr;
    logic              ld_accept;
    logic              ptr_clr;
    logic              run;

    logic              i_in_ram, d_in_ram, d_in_mmio;
    logic [2:0]        d_off;
    logic              core_ram_we, mmio_we;
    logic [DATA_W-1:0] ram_irdata, ram_drdata;
    logic [DATA_W-1:0] mmio_rdata;
    logic [DATA_W-1:0] cycle_rd;
    logic              unused_addr_lsb;

    // Address decode; bit 0 is the byte lane and is ignored.
    assign i_in_ram  = (iaddr >> (ADDR_W + 1)) == 16'd0;
    assign d_in_ram  = (daddr >> (ADDR_W + 1)) == 16'd0;
    assign d_in_mmio = daddr[15:3] == MMIO_BASE[15:3];
    assign d_off     = {daddr[2:1], 1'b0};
    assign unused_addr_lsb = &{1'b0, iaddr[0], daddr[0]};

    assign run         = (state == RUN);
    assign core_ram_we = dwe && run && d_in_ram;
    assign mmio_we     = dwe && run && d_in_mmio;

    // FSM state register plus registered handshake/reset outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cpu_rst  <= 1'b1;
            ld_ready <= 1'b0;
            ptr      <= '0;
        end else begin
            state    <= next_state;
            cpu_rst  <= (next_state != RUN);
            ld_ready <= (next_state == LOAD);
            if (ptr_clr) begin
                ptr <= '0;
            end else if (ld_accept) begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    // Next state; ld_start always restarts the load and drops any same-cycle word.
    always_comb begin
        next_state = state;
        ld_accept  = 1'b0;
        ptr_clr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ld_start) begin
                    next_state = LOAD;
                    ptr_clr    = 1'b1;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    ptr_clr = 1'b1;
                end else if (ld_valid && ld_ready) begin
                    ld_accept = 1'b1;
                    if (ld_last) begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (ld_start) begin
                    next_state = LOAD;
                    ptr_clr    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // GPIO output register survives reloads; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out <= '0;
        end else if (mmio_we && d_off == MMIO_GPIO_OUT) begin
            gpio_out <= dwdata;
        end
    end

`ifdef RISC16_MEM_RESP_CYCLE_CNT_EN
    logic [DATA_W-1:0] cycle_cnt;
    logic              cycle_wr;

    assign cycle_wr = mmio_we && d_off == MMIO_CYCLE;

    // RUN-cycle counter; a write or a (re)load clears it ahead of the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (cycle_wr || next_state == LOAD) begin
            cycle_cnt <= '0;
        end else if (run) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign cycle_rd = cycle_cnt;
`else
    assign cycle_rd = '0;
`endif

    // RAM writes are either loader or core; the FSM never allows both.
    risc16_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .iaddr  (iaddr[ADDR_W:1]),
        .irdata (ram_irdata),
        .daddr  (daddr[ADDR_W:1]),
        .drdata (ram_drdata),
        .we     (ld_accept || core_ram_we),
        .waddr  (ld_accept ? ptr : daddr[ADDR_W:1]),
        .wdata  (ld_accept ? ld_data : dwdata)
    );

    // MMIO read mux; STATUS is only visible in RUN, where it reads 1.
    always_comb begin
        mmio_rdata = '0;
        unique case (d_off)
            MMIO_GPIO_OUT: mmio_rdata = gpio_out;
            MMIO_GPIO_IN:  mmio_rdata = gpio_in;
            MMIO_CYCLE:    mmio_rdata = cycle_rd;
            MMIO_STATUS:   mmio_rdata = {15'b0, 1'b1};
            default:       mmio_rdata = '0;
        endcase
    end

    assign irdata = (ioe && run && i_in_ram) ? ram_irdata : NOP;

    always_comb begin
        drdata = '0;
        if (doe && run) begin
            if (d_in_ram) begin
                drdata = ram_drdata;
            end else if (d_in_mmio) begin
                drdata = mmio_rdata;
            end
        end
    end

endmodule
